nn_layer_sequencer: RTL

Central controller for the digit-recognition pipeline. It runs the four compute stages strictly in order: average pooling, hidden dense layer, output dense layer, then max-select. It issues a start pulse and holds a level enable for each stage, waits for that stage's done, and latches the recognised digit. It sits between the top-level inference request and the layer modules, replacing ad-hoc enable chaining with one FSM, a per-stage watchdog and a latency counter.

---
 rtl/nn_pkg.sv | 31 +++
 rtl/nn_stage_watchdog.sv | 43 ++++
 rtl/nn_layer_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared types and constants for the digit-recognition pipeline.
//   nn_stage_e      : compute stage index (pool, dense1, dense2, select)
//   nn_seq_state_e  : layer sequencer FSM states
//   nn_stage_onehot : stage index to one-hot stage vector
package nn_pkg;

  localparam int unsigned NN_NUM_STAGES = 4;
  localparam int unsigned NN_DIGIT_W    = 4;
  localparam int unsigned NN_STAGE_W    = 2;

  typedef enum logic [NN_STAGE_W-1:0] {
    STG_POOL   = 2'd0,
    STG_DENSE1 = 2'd1,
    STG_DENSE2 = 2'd2,
    STG_SELECT = 2'd3
  } nn_stage_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } nn_seq_state_e;

  // One-hot vector with the bit of the given stage set.
  function automatic logic [NN_NUM_STAGES-1:0] nn_stage_onehot(input logic [NN_STAGE_W-1:0] stage);
    return NN_NUM_STAGES'(1) << stage;
  endfunction

endpackage

// File: rtl/nn_stage_watchdog.sv
// Per-stage watchdog: counts RUN cycles of the active stage and flags expiry
// on the TIMEOUT_CYCLES-th cycle the stage has been running.
// Ports:
//   i_clk, i_reset  : clock, synchronous active-high reset
//   i_clear         : high in the first cycle of a stage (count restarts at 1)
//   i_count_en      : high in every RUN cycle
//   o_expired_c     : combinational; this cycle is the TIMEOUT_CYCLES-th RUN cycle
module nn_stage_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired_c
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cur;

  // Running count including the current cycle; saturates so it cannot wrap.
  always_comb begin
    w_cur = r_cnt;
    if (i_clear) begin
      w_cur = CW'(1);
    end else if (r_cnt != '1) begin
      w_cur = r_cnt + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_count_en) begin
      r_cnt <= w_cur;
    end
  end

  assign o_expired_c = i_count_en && (w_cur >= CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/nn_layer_sequencer.sv
// Central controller of the digit-recognition pipeline. Runs pool, dense1,
// dense2 and select strictly in order, latches the recognised digit and
// measures total run latency.
// Optional feature: define NN_SEQ_WATCHDOG_EN to add a per-stage timeout that
// moves the FSM to ERROR; otherwise error/err_stage are tied to 0.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   start, abort             : inference request / cancel
//   stage_start/stage_enable : one-hot launch pulse / level enable per stage
//   stage_done               : per-stage done (level or pulse)
//   stage_clear              : one-cycle clear of layer state before a run
//   digit_in/digit_out       : select-stage digit / latched result
//   digit_valid, nn_done     : result valid level / completion pulse
//   busy, error, err_stage   : activity, timeout flag, timed-out stage
//   cycle_count              : cycles taken by the last run (saturating)
module nn_layer_sequencer
  import nn_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned CNT_W          = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  output logic [NN_NUM_STAGES-1:0] stage_start,
  output logic [NN_NUM_STAGES-1:0] stage_enable,
  input  logic [NN_NUM_STAGES-1:0] stage_done,
  output logic                     stage_clear,
  input  logic [NN_DIGIT_W-1:0]    digit_in,
  output logic [NN_DIGIT_W-1:0]    digit_out,
  output logic                     digit_valid,
  output logic                     nn_done,
  output logic                     busy,
  output logic                     error,
  output logic [NN_STAGE_W-1:0]    err_stage,
  output logic [CNT_W-1:0]         cycle_count
);

  nn_seq_state_e             r_state;
  nn_seq_state_e             w_state_nxt;
  logic [NN_STAGE_W-1:0]     r_stage;
  logic [NN_STAGE_W-1:0]     w_stage_nxt;

  logic [NN_NUM_STAGES-1:0]  r_stage_start;
  logic [NN_NUM_STAGES-1:0]  r_stage_enable;
  logic                      r_stage_clear;
  logic [NN_DIGIT_W-1:0]     r_digit_out;
  logic                      r_digit_valid;
  logic                      r_nn_done;
  logic                      r_busy;
  logic [CNT_W-1:0]          r_cycle_count;

  logic                      w_accept;
  logic                      w_launch;
  logic                      w_final;
  logic                      w_first;
  logic                      w_run;
  logic                      w_expired;
  logic [NN_NUM_STAGES-1:0]  w_stage_start_nxt;
  logic [NN_NUM_STAGES-1:0]  w_stage_enable_nxt;
  logic                      w_stage_clear_nxt;
  logic                      w_nn_done_nxt;
  logic                      w_busy_nxt;

  // The launch pulse register marks the first cycle of a stage; done is ignored then.
  assign w_first = |r_stage_start;
  assign w_run   = (r_state == ST_RUN);

`ifdef NN_SEQ_WATCHDOG_EN
  logic                  r_error;
  logic [NN_STAGE_W-1:0] r_err_stage;

  nn_stage_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_clear     (w_first),
    .i_count_en  (w_run),
    .o_expired_c (w_expired)
  );

  // Error flag and offending stage; both cleared by the next accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_error     <= 1'b0;
      r_err_stage <= '0;
    end else begin
      r_error <= (w_state_nxt == ST_ERROR);
      if (w_accept) begin
        r_err_stage <= '0;
      end else if (w_run && (w_state_nxt == ST_ERROR)) begin
        r_err_stage <= r_stage;
      end
    end
  end

  assign error     = r_error;
  assign err_stage = r_err_stage;
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;

  assign w_expired = 1'b0;
  assign error     = 1'b0;
  assign err_stage = '0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_stage <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_stage <= w_stage_nxt;
    end
  end

  // Next-state logic; abort beats done, done beats timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_stage_nxt = r_stage;
    w_accept    = 1'b0;
    w_launch    = 1'b0;
    w_final     = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_ERROR: begin
        if (start) begin
          w_state_nxt = ST_CLEAR;
          w_stage_nxt = '0;
          w_accept    = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RUN;
          w_stage_nxt = '0;
          w_launch    = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (!w_first && stage_done[r_stage]) begin
          if (r_stage != STG_SELECT) begin
            w_stage_nxt = r_stage + NN_STAGE_W'(1);
            w_launch    = 1'b1;
          end else begin
            w_state_nxt = ST_DONE;
            w_final     = 1'b1;
          end
        end else if (w_expired) begin
          w_state_nxt = ST_ERROR;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode for the upcoming cycle, registered below.
  always_comb begin
    w_stage_start_nxt  = '0;
    w_stage_enable_nxt = '0;
    w_stage_clear_nxt  = (w_state_nxt == ST_CLEAR);
    w_nn_done_nxt      = w_final;
    w_busy_nxt         = (w_state_nxt == ST_CLEAR) || (w_state_nxt == ST_RUN);
    if (w_launch) begin
      w_stage_start_nxt = nn_stage_onehot(w_stage_nxt);
    end
    if (w_state_nxt == ST_RUN) begin
      w_stage_enable_nxt = nn_stage_onehot(w_stage_nxt);
    end
  end

  // Output registers, result latch and latency counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage_start  <= '0;
      r_stage_enable <= '0;
      r_stage_clear  <= 1'b0;
      r_nn_done      <= 1'b0;
      r_busy         <= 1'b0;
      r_digit_out    <= '0;
      r_digit_valid  <= 1'b0;
      r_cycle_count  <= '0;
    end else begin
      r_stage_start  <= w_stage_start_nxt;
      r_stage_enable <= w_stage_enable_nxt;
      r_stage_clear  <= w_stage_clear_nxt;
      r_nn_done      <= w_nn_done_nxt;
      r_busy         <= w_busy_nxt;
      if (w_final) begin
        r_digit_out <= digit_in;
      end
      if (w_accept) begin
        r_digit_valid <= 1'b0;
      end else if (w_final) begin
        r_digit_valid <= 1'b1;
      end
      // Counts CLEAR and every RUN cycle, including the one sampling the final done.
      if (w_accept) begin
        r_cycle_count <= '0;
      end else if (((r_state == ST_CLEAR) || w_run) && (r_cycle_count != '1)) begin
        r_cycle_count <= r_cycle_count + CNT_W'(1);
      end
    end
  end

  assign stage_start  = r_stage_start;
  assign stage_enable = r_stage_enable;
  assign stage_clear  = r_stage_clear;
  assign nn_done      = r_nn_done;
  assign busy         = r_busy;
  assign digit_out    = r_digit_out;
  assign digit_valid  = r_digit_valid;
  assign cycle_count  = r_cycle_count;

endmodule
